promedio_ventana_param: RTL and testbench
=========================================

// Module: promedio_ventana_param
// PURPOSE
//  Parametrised averager for unsigned sample streams. Averages 2^LOG2_N accepted samples.
//  Two modes:
//   - Block: one result per N samples.
//   - Sliding: one result per sample once the window is full.
//  Sits between a sample source (ADC/sensor front-end) and downstream logic consuming out_data/out_valid.
//  Supersedes the fixed 4-sample averager: adds width/depth generics, a valid handshake,
//  a sliding mode and a correctly sized accumulator.
// PARAMETERS
//  W_IN    16  input sample width (unsigned)
//  W_OUT   16  output width; W_OUT >= W_IN required (zero-extended result)
//  LOG2_N  2   log2 of window length N; legal range 0..8
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       synchronous, active-high reset
//  en         in   1       block enable; low = synchronous clear of all averaging state
//  mode       in   1       0 = block average, 1 = sliding average
//  in_valid   in   1       in_data is a sample this cycle
//  in_data    in   W_IN    unsigned sample
//  out_data   out  W_OUT   last average (held between results)
//  out_valid  out  1       one-cycle pulse: out_data updated this cycle
//  win_full   out  1       sliding mode: window holds N samples; block mode: always 0
// BEHAVIOUR
//  - Reset: out_data=0, out_valid=0, win_full=0, acc=0, cnt=0, wr_ptr=0, fill=0.
//  - Accept: a sample is accepted iff en & in_valid. Cycles without in_valid are ignored;
//    the window counts accepted samples only.
//  - Accumulator width: W_ACC = W_IN+LOG2_N, so N full-scale samples never overflow.
//  - Result: floor(sum >> LOG2_N), unsigned truncation, zero-extended to W_OUT.
//  - Latency: out_data/out_valid are registered one cycle after the completing sample's
//    accept edge.
//  - Block mode (mode=0):
//    - On accept, acc <= acc+in_data and cnt <= cnt+1.
//    - When the sample is the Nth (cnt==N-1): result = (acc+in_data)>>LOG2_N,
//      out_valid pulses, then acc <= 0 and cnt <= 0 (back-to-back windows, no dead cycle).
//  - Sliding mode (mode=1):
//    - Ring buffer of N entries, write pointer wr_ptr wraps N-1 -> 0. fill saturates at N.
//    - On accept: old = (fill==N) ? buf[wr_ptr] : 0; acc <= acc+in_data-old;
//      buf[wr_ptr] <= in_data.
//    - out_valid pulses on every accept for which fill_after == N.
//    - No buffer clear is needed; stale entries are masked by fill.
//  - win_full: registered, equals (fill==N) in sliding mode.
//  - en low:
//    - Synchronous clear of acc, cnt, wr_ptr, fill, win_full and out_valid next edge.
//    - out_data holds its last value.
//    - A sample presented with en=0 is dropped.
//  - Mode change:
//    - mode is registered internally (mode_q).
//    - If mode != mode_q while en=1, that cycle performs the same clear as en low,
//      and its sample is dropped.
//  - LOG2_N=0:
//    - Pass-through: every accepted sample gives out_data=in_data one cycle later.
//    - win_full=1 after the first sliding-mode accept.
//  - Simultaneous events, priority: reset > en low > mode change > accept.
// STRUCTURE
//  - Package promedio_pkg:
//    - MODE_BLOCK=1'b0, MODE_SLIDE=1'b1.
//    - Function acc_width(w_in, log2_n).
//    - Legal-range check for LOG2_N.
//  - Sub-module promedio_ring (N x W_IN ring buffer):
//    - Ports: clk, wr_en, wr_ptr, wr_data, rd_data.
//    - Combinational read of the slot about to be overwritten.
//  - Top holds acc, cnt/fill/ptr counters, mode_q and output registers.
// TESTING (W_IN=16, W_OUT=16, LOG2_N=2 unless noted)
//  1. Block: accept 10,20,30,41 consecutively -> one cycle after 41: out_data=25,
//     out_valid=1 for exactly one cycle; next 4 samples 4,4,4,4 -> out_data=4.
//  2. Sliding: accept 4,8,12,16,20,24 -> no valid for first 3; then out_data=10,14,18
//     on successive cycles; win_full rises with 4th accept.
//  3. Gaps/overflow: 4x 0xFFFF with in_valid low 2 cycles between each -> single
//     result 0xFFFF, no wrap; idle cycles do not advance cnt.
//  4. Clear: block mode, accept 100,100 then en=0 one cycle, then 1,1,1,1 -> out_data=1
//     (first two discarded); out_data holds previous value during en=0.
//  5. Mode switch/reset: sliding full window, toggle mode with in_valid=1 -> sample dropped,
//     win_full=0, next result after 4 new accepts; reset mid-window -> all outputs 0.
//  6. LOG2_N=0 build: accept 7,9 -> out_data=7 then 9, each one cycle after accept,
//     out_valid each cycle.

Source files
------------

// File: rtl/promedio_pkg.sv
// Shared constants and helpers for the windowed sample averager.
// Mode encodings, accumulator sizing and window-depth legality.
package promedio_pkg;

    localparam logic MODE_BLOCK = 1'b0;
    localparam logic MODE_SLIDE = 1'b1;

    localparam int LOG2_N_MAX = 8;

    function automatic int acc_width(input int w_in, input int log2_n);
        return w_in + log2_n;
    endfunction

    function automatic bit log2n_ok(input int log2_n);
        return (log2_n >= 0) && (log2_n <= LOG2_N_MAX);
    endfunction

endpackage

// File: rtl/promedio_ring.sv
// N x W ring buffer for the sliding window.
// Read is combinational from the slot the next write will overwrite.
module promedio_ring
    import promedio_pkg::*;
#(
    parameter int W      = 16,
    parameter int LOG2_N = 2,
    localparam int PW    = (LOG2_N == 0) ? 1 : LOG2_N
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [PW-1:0] wr_ptr,
    input  logic [W-1:0]  wr_data,
    output logic [W-1:0]  rd_data
);

    generate
        if (LOG2_N == 0) begin : g_one
            logic [W-1:0] r_slot;
            logic         w_unused_ptr;

            assign w_unused_ptr = &wr_ptr;

            always_ff @(posedge clk) begin
                if (wr_en) begin
                    r_slot <= wr_data;
                end
            end

            assign rd_data = r_slot;
        end else begin : g_mem
            logic [W-1:0] r_mem [1 << LOG2_N];

            always_ff @(posedge clk) begin
                if (wr_en) begin
                    r_mem[wr_ptr] <= wr_data;
                end
            end

            assign rd_data = r_mem[wr_ptr];
        end
    endgenerate

endmodule

// File: rtl/promedio_ventana_param.sv
// Block / sliding averager over 2^LOG2_N accepted unsigned samples.
// Result is floor(sum / N), registered one cycle after the completing sample.
module promedio_ventana_param
    import promedio_pkg::*;
#(
    parameter int W_IN   = 16,
    parameter int W_OUT  = 16,
    parameter int LOG2_N = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             mode,
    input  logic             in_valid,
    input  logic [W_IN-1:0]  in_data,
    output logic [W_OUT-1:0] out_data,
    output logic             out_valid,
    output logic             win_full
);

    localparam int N     = 1 << LOG2_N;
    localparam int W_ACC = acc_width(W_IN, LOG2_N);
    localparam int PW    = (LOG2_N == 0) ? 1 : LOG2_N;
    localparam int FW    = LOG2_N + 1;

    localparam logic [PW-1:0] LAST = PW'(N - 1);
    localparam logic [FW-1:0] FULL = FW'(N);

    generate
        if (!log2n_ok(LOG2_N)) begin : g_bad_log2n
            $error("promedio_ventana_param: LOG2_N must be 0..8");
        end
        if (W_OUT < W_IN) begin : g_bad_wout
            $error("promedio_ventana_param: W_OUT must be >= W_IN");
        end
    endgenerate

    logic [W_ACC-1:0] r_acc;
    logic [PW-1:0]    r_cnt;
    logic [PW-1:0]    r_ptr;
    logic [FW-1:0]    r_fill;
    logic             r_mode_q;
    logic [W_OUT-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_win_full;

    logic             w_clear;
    logic             w_accept;
    logic             w_slide;
    logic             w_full;
    logic             w_blk_done;
    logic [W_IN-1:0]  w_rd;
    logic [W_ACC-1:0] w_old;
    logic [W_ACC-1:0] w_sum_blk;
    logic [W_ACC-1:0] w_sum_sld;
    logic [FW-1:0]    w_fill_nx;
    logic [PW-1:0]    w_ptr_nx;
    logic [W_IN-1:0]  w_avg;

    // A mode flip behaves exactly like en low for that cycle.
    assign w_clear    = !en || (mode != r_mode_q);
    assign w_accept   = in_valid && !w_clear;
    assign w_slide    = (r_mode_q == MODE_SLIDE);
    assign w_full     = (r_fill == FULL);
    assign w_blk_done = (r_cnt == LAST);

    assign w_old     = w_full ? W_ACC'(w_rd) : '0;
    assign w_sum_blk = r_acc + W_ACC'(in_data);
    assign w_sum_sld = w_sum_blk - w_old;
    assign w_fill_nx = w_full ? FULL : r_fill + 1'b1;
    assign w_ptr_nx  = (r_ptr == LAST) ? '0 : r_ptr + 1'b1;

    assign w_avg = w_slide ? w_sum_sld[W_ACC-1:LOG2_N]
                           : w_sum_blk[W_ACC-1:LOG2_N];

    promedio_ring #(
        .W      (W_IN),
        .LOG2_N (LOG2_N)
    ) u_ring (
        .clk     (clk),
        .wr_en   (w_accept && w_slide),
        .wr_ptr  (r_ptr),
        .wr_data (in_data),
        .rd_data (w_rd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ptr       <= '0;
            r_fill      <= '0;
            r_mode_q    <= MODE_BLOCK;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_win_full  <= 1'b0;
        end else begin
            r_mode_q    <= mode;
            r_out_valid <= 1'b0;
            if (w_clear) begin
                r_acc      <= '0;
                r_cnt      <= '0;
                r_ptr      <= '0;
                r_fill     <= '0;
                r_win_full <= 1'b0;
            end else if (w_accept) begin
                if (w_slide) begin
                    r_acc      <= w_sum_sld;
                    r_ptr      <= w_ptr_nx;
                    r_fill     <= w_fill_nx;
                    r_win_full <= (w_fill_nx == FULL);
                    if (w_fill_nx == FULL) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= W_OUT'(w_avg);
                    end
                end else if (w_blk_done) begin
                    r_acc       <= '0;
                    r_cnt       <= '0;
                    r_out_valid <= 1'b1;
                    r_out_data  <= W_OUT'(w_avg);
                end else begin
                    r_acc <= w_sum_blk;
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign win_full  = r_win_full;

endmodule

// File: tb/tb_promedio_ventana_param.sv
// Scoreboard bench: N=4 averager in both modes plus an N=1 pass-through build.
module tb_promedio_ventana_param;

    logic        clk;
    logic        reset;
    logic        en;
    logic        mode;
    logic        in_valid;
    logic [15:0] in_data;
    logic [15:0] out_data;
    logic        out_valid;
    logic        win_full;

    logic        in_valid1;
    logic [15:0] in_data1;
    logic [15:0] out_data1;
    logic        out_valid1;
    logic        win_full1;

    int n_tests;
    int n_fail;

    int q0[$];
    int q1[$];

    int   m_sum;
    int   m_cnt;
    int   m_win[$];
    logic m_slide;

    promedio_ventana_param #(
        .W_IN   (16),
        .W_OUT  (16),
        .LOG2_N (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .win_full  (win_full)
    );

    promedio_ventana_param #(
        .W_IN   (16),
        .W_OUT  (16),
        .LOG2_N (0)
    ) dut1 (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .mode      (mode),
        .in_valid  (in_valid1),
        .in_data   (in_data1),
        .out_data  (out_data1),
        .out_valid (out_valid1),
        .win_full  (win_full1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (q0.size() == 0) chk("unexp_valid", 32'd1, 32'd0);
            else chk("avg", 32'(out_data), q0.pop_front());
        end
        if (!reset && out_valid1) begin
            if (q1.size() == 0) chk("unexp_valid1", 32'd1, 32'd0);
            else chk("avg1", 32'(out_data1), q1.pop_front());
        end
    end

    task automatic model_clear();
        m_sum = 0;
        m_cnt = 0;
        m_win.delete();
    endtask

    task automatic send(input int d);
        logic ev;
        int   s;
        ev       = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'(d);
        if (!m_slide) begin
            m_sum += d;
            m_cnt++;
            if (m_cnt == 4) begin
                q0.push_back(m_sum / 4);
                ev    = 1'b1;
                m_sum = 0;
                m_cnt = 0;
            end
        end else begin
            m_win.push_back(d);
            if (m_win.size() > 4) void'(m_win.pop_front());
            if (m_win.size() == 4) begin
                s = 0;
                foreach (m_win[i]) s += m_win[i];
                q0.push_back(s / 4);
                ev = 1'b1;
            end
        end
        @(negedge clk);
        chk("valid_lat", 32'(out_valid), 32'(ev));
        in_valid = 1'b0;
    endtask

    task automatic send1(input int d);
        in_valid1 = 1'b1;
        in_data1  = 16'(d);
        q1.push_back(d);
        @(negedge clk);
        chk("valid_lat1", 32'(out_valid1), 32'd1);
        in_valid1 = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        en        = 1'b0;
        mode      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_valid1 = 1'b0;
        in_data1  = '0;
        m_slide   = 1'b0;
        model_clear();
        idle(2);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_full", 32'(win_full), 32'd0);
        reset = 1'b0;
        en    = 1'b1;
        idle(1);

        // block averages, back to back
        send(10); send(20); send(30); send(41);
        send(4); send(4); send(4); send(4);

        // full-scale samples with idle gaps
        for (int i = 0; i < 4; i++) begin
            send(16'hFFFF);
            idle(2);
        end
        chk("blk_full", 32'(win_full), 32'd0);

        // en low clears partial window and drops its sample
        send(100); send(100);
        en       = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'd7;
        @(negedge clk);
        chk("en0_hold", 32'(out_data), 32'hFFFF);
        chk("en0_valid", 32'(out_valid), 32'd0);
        en       = 1'b1;
        in_valid = 1'b0;
        model_clear();
        send(1); send(1); send(1); send(1);

        // sliding mode
        mode = 1'b1;
        idle(1);
        m_slide = 1'b1;
        model_clear();
        send(4); send(8); send(12);
        chk("sld_full3", 32'(win_full), 32'd0);
        send(16);
        chk("sld_full4", 32'(win_full), 32'd1);
        send(20); send(24);

        // mode flip with a sample present: dropped, state cleared
        mode     = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'd99;
        @(negedge clk);
        chk("flip_full", 32'(win_full), 32'd0);
        chk("flip_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        m_slide  = 1'b0;
        model_clear();
        send(8); send(8); send(8); send(8);

        // reset mid-window
        send(5); send(5);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_full", 32'(win_full), 32'd0);
        reset = 1'b0;
        model_clear();
        send(2); send(2); send(2); send(2);

        // N=1 build: pass-through
        send1(7); send1(9);
        mode = 1'b1;
        idle(1);
        m_slide = 1'b1;
        send1(5);
        chk("p_full", 32'(win_full1), 32'd1);
        idle(2);

        chk("q0_empty", 32'(q0.size()), 32'd0);
        chk("q1_empty", 32'(q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
